// File: rtl/subtractor_fault_bist_if.sv
// Bus between the subtractor BIST controller and its environment: run control,
// vectors to the subtractor under test, its response, and the diagnosis results.
interface subtractor_fault_bist_if #(
  parameter int WIDTH = 4
);
  localparam int N = 2 * WIDTH + 1;

  logic             start;
  logic [WIDTH-1:0] dut_a;
  logic [WIDTH-1:0] dut_b;
  logic             dut_bin;
  logic [WIDTH-1:0] dut_d;
  logic             dut_bout;
  logic             busy;
  logic             done;
  logic             pass;
  logic             z_fail;
  logic             o_fail;
  logic [N-1:0]     sa0_map;
  logic [N-1:0]     sa1_map;
  logic [7:0]       err_cnt;

  modport master (
    input  start, dut_d, dut_bout,
    output dut_a, dut_b, dut_bin, busy, done, pass,
           z_fail, o_fail, sa0_map, sa1_map, err_cnt
  );

  modport slave (
    output start, dut_d, dut_bout,
    input  dut_a, dut_b, dut_bin, busy, done, pass,
           z_fail, o_fail, sa0_map, sa1_map, err_cnt
  );
endinterface

// File: rtl/subtractor_fault_bist.sv
// BIST controller for a WIDTH-bit ripple subtractor: applies all-zero, all-one,
// walking-one and walking-zero vectors and builds stuck-at diagnosis maps.
module subtractor_fault_bist #(
  parameter int WIDTH = 4,
  parameter int LAT   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  subtractor_fault_bist_if.master bus
);
  localparam int N  = 2 * WIDTH + 1;
  localparam int NV = 2 * N + 2;
  localparam int KW = $clog2(NV);
  localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_WAIT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CW-1:0]    wcnt_q, wcnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             bin_q, bin_d;
  logic             z_q, z_d, o_q, o_d;
  logic [N-1:0]     sa0_q, sa0_d, sa1_q, sa1_d;
  logic [7:0]       err_q, err_d;

  logic             accept;
  logic             last_wait;
  logic             last_vec;
  logic             mismatch;
  logic [N-1:0]     vec;
  logic [WIDTH:0]   gold;

  assign accept    = bus.start && (state_q == S_IDLE || state_q == S_DONE);
  assign last_wait = (state_q == S_WAIT) && (wcnt_q == CW'(LAT));
  assign last_vec  = (k_q == KW'(NV - 1));

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned and infers a latch.
  always_comb begin
    vec = '0;
    if (k_q == KW'(1))
      vec = '1;
    else if (k_q >= KW'(2) && k_q < KW'(N + 2))
      vec = N'(1) << (k_q - KW'(2));
    else if (k_q >= KW'(N + 2))
      vec = ~(N'(1) << (k_q - KW'(N + 2)));
  end

  // Golden response is taken from the registered vector, which stays stable through WAIT.
  assign gold     = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, bin_q};
  assign mismatch = ({bus.dut_bout, bus.dut_d} != gold);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (accept) state_d = S_APPLY;
      S_APPLY:        state_d = S_WAIT;
      S_WAIT:         if (last_wait) state_d = last_vec ? S_DONE : S_APPLY;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    k_d    = k_q;
    wcnt_d = wcnt_q;
    a_d    = a_q;
    b_d    = b_q;
    bin_d  = bin_q;
    z_d    = z_q;
    o_d    = o_q;
    sa0_d  = sa0_q;
    sa1_d  = sa1_q;
    err_d  = err_q;
    if (accept) begin
      k_d   = '0;
      z_d   = 1'b0;
      o_d   = 1'b0;
      sa0_d = '0;
      sa1_d = '0;
      err_d = '0;
    end else if (state_q == S_APPLY) begin
      {a_d, b_d, bin_d} = vec;
      wcnt_d            = '0;
    end else if (state_q == S_WAIT) begin
      if (!last_wait) begin
        wcnt_d = wcnt_q + CW'(1);
      end else begin
        if (mismatch) begin
          // The current vector itself marks the line under test in either walking phase.
          if (k_q == KW'(0))           z_d   = 1'b1;
          else if (k_q == KW'(1))      o_d   = 1'b1;
          else if (k_q < KW'(N + 2))   sa0_d = sa0_q | vec;
          else                         sa1_d = sa1_q | ~vec;
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
        end
        if (!last_vec) k_d = k_q + KW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      wcnt_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      bin_q   <= 1'b0;
      z_q     <= 1'b0;
      o_q     <= 1'b0;
      sa0_q   <= '0;
      sa1_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      wcnt_q  <= wcnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      bin_q   <= bin_d;
      z_q     <= z_d;
      o_q     <= o_d;
      sa0_q   <= sa0_d;
      sa1_q   <= sa1_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    bus.busy = (state_q == S_APPLY) || (state_q == S_WAIT);
    bus.done = (state_q == S_DONE);
    bus.pass = (state_q == S_DONE) && (err_q == 8'd0);
  end

  assign bus.dut_a   = a_q;
  assign bus.dut_b   = b_q;
  assign bus.dut_bin = bin_q;
  assign bus.z_fail  = z_q;
  assign bus.o_fail  = o_q;
  assign bus.sa0_map = sa0_q;
  assign bus.sa1_map = sa1_q;
  assign bus.err_cnt = err_q;
endmodule

// File: doc/subtractor_fault_bist.md
# subtractor_fault_bist

Parametrised built-in self-test controller for a WIDTH-bit ripple subtractor (D = A − B − Bin). It drives a fixed sequence of walking-one and walking-zero vectors into the subtractor under test and compares each response with an internal golden model. It reports per-input-line stuck-at-0 and stuck-at-1 diagnosis maps. It sits beside the subtractor datapath and replaces bench-only fault checks with a synthesizable, restartable run.

## Interface
Parameters:
- WIDTH, 4, operand width of A and B (≥1); WIDTH=1 tests a single full subtractor
- LAT, 0, pipeline latency of the subtractor under test in clock cycles (0 = combinational)
- N (localparam), 2*WIDTH+1, number of input lines

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a run; sampled only in IDLE or DONE
- dut_a  out  WIDTH  registered A vector to the subtractor under test
- dut_b  out  WIDTH  registered B vector
- dut_bin  out  1  registered borrow-in
- dut_d  in  WIDTH  difference returned by the subtractor under test
- dut_bout  in  1  borrow-out returned by the subtractor under test
- busy  out  1  run in progress
- done  out  1  run complete; held until next accepted start or rst
- pass  out  1  done and zero mismatches
- z_fail  out  1  all-zero vector mismatched
- o_fail  out  1  all-ones vector mismatched
- sa0_map  out  N  bit i set: walking-one vector for line i mismatched
- sa1_map  out  N  bit i set: walking-zero vector for line i mismatched
- err_cnt  out  8  mismatching vectors this run, saturating at 255

## Operation
- Line numbering: the concatenated vector V = {A, B, Bin}. Line 0 = Bin. Lines 1..WIDTH = B[0..WIDTH-1]. Lines WIDTH+1..2*WIDTH = A[0..WIDTH-1].
- Vector order, index k = 0..2N+1:
  - k=0: all zeros
  - k=1: all ones
  - k=2..N+1: only line k−2 is 1
  - k=N+2..2N+1: only line k−N−2 is 0
- Golden model: {gold_bout, gold_d} = ({1'b0,A} − {1'b0,B} − Bin) truncated to WIDTH+1 bits. gold_bout is the MSB.
- Mismatch: {dut_bout, dut_d} ≠ {gold_bout, gold_d}. On a mismatch, set the flag mapped to the current vector and increment err_cnt (saturating).
- FSM states:
  - IDLE: start → APPLY. Clear all maps, z_fail, o_fail, err_cnt, done and pass. Set k=0 and busy=1.
  - APPLY (1 cycle): register vector k onto dut_*; clear the wait counter → WAIT.
  - WAIT (LAT+1 cycles): on the final WAIT cycle, compare the response and update the flags. If k = 2N+1 → DONE; otherwise k++ → APPLY.
  - DONE: busy=0, done=1, pass = (err_cnt==0). start → same actions as IDLE+start.
- start while busy is ignored.
- Single-fault signatures (required diagnosis):
  - stuck-at-0 on line i: o_fail=1, z_fail=0, sa0_map = 1<<i, sa1_map = ~(1<<i), err_cnt = N+1
  - stuck-at-1 on line j: z_fail=1, o_fail=0, sa1_map = 1<<j, sa0_map = ~(1<<j), err_cnt = N+1
- Multiple faults: raw maps reported; no further decoding.

## Timing
- Reset values: dut_a, dut_b, dut_bin = 0; busy, done, pass, z_fail, o_fail = 0; sa0_map, sa1_map = 0; err_cnt = 0; state IDLE.
- rst mid-run: abort the run. All outputs take their reset values on the next edge. No partial results are retained.
- start accepted at edge t: busy=1 from t+1.
- Per vector: LAT+2 cycles, split as 1 APPLY + LAT+1 WAIT.
- The response is sampled exactly LAT+1 edges after dut_* change.
- Run length: (2N+2)(LAT+2) cycles from busy rising to done rising.
- busy falls and done rises on the same edge.
- Flags update on the edge ending each compare cycle and are visible during the run.
- rst and start high together: rst wins.

## Test plan
- Fault-free subtractor, WIDTH=4, LAT=0 (N=9, 20 vectors) → done after 40 cycles, pass=1, maps=0, z_fail=o_fail=0, err_cnt=0.
- A[2] forced to 0 (line 7), WIDTH=4 → o_fail=1, z_fail=0, sa0_map=9'h080, sa1_map=9'h17F, err_cnt=10, pass=0.
- Bin forced to 1 (line 0), WIDTH=4 → z_fail=1, o_fail=0, sa1_map=9'h001, sa0_map=9'h1FE, err_cnt=10.
- WIDTH=1, LAT=2, A forced to 0 (line 2) → 8 vectors, 32 cycles; sa0_map=3'b100, sa1_map=3'b011, o_fail=1.
- start re-pulsed during a run at cycle 10 → ignored, done still at cycle 40. rst at cycle 15 of a run → all outputs 0 next cycle. A new start then gives a clean 40-cycle run.
- Fault-free run completes, then start from DONE → maps cleared and the run repeats with identical results.
